// File: rtl/mem_access_pkg.sv
// Shared definitions for the UART memory-access protocol (host and responder).
// Holds opcodes, frame lengths, the host FSM state type, the captured command
// payload, and the frame byte selector used by the host.
package mem_access_pkg;

  localparam int unsigned ADDR_W       = 16;
  localparam int unsigned DATA_W       = 32;
  localparam int unsigned WR_FRAME_LEN = 8;
  localparam int unsigned RD_FRAME_LEN = 5;

  localparam logic [7:0] OP_WRITE = 8'h0F;
  localparam logic [7:0] OP_READ  = 8'hFF;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_WAIT_TX,
    ST_RECV,
    ST_FIN
  } state_e;

  // Captured command; addresses are already word-aligned.
  typedef struct packed {
    logic              rw;
    logic [ADDR_W-1:0] addr;
    logic [ADDR_W-1:0] end_addr;
    logic [3:0]        we;
    logic [DATA_W-1:0] wdata;
  } cmd_t;

  // Byte at position idx of the frame for cmd (write: 8 bytes, read: 5 bytes).
  function automatic logic [7:0] frame_byte(input cmd_t cmd, input logic [2:0] idx);
    logic [7:0] b;
    b = 8'h00;
    if (cmd.rw) begin
      case (idx)
        3'd0:    b = OP_READ;
        3'd1:    b = cmd.end_addr[7:0];
        3'd2:    b = cmd.end_addr[15:8];
        3'd3:    b = cmd.addr[7:0];
        3'd4:    b = cmd.addr[15:8];
        default: b = 8'h00;
      endcase
    end else begin
      case (idx)
        3'd0:    b = OP_WRITE;
        3'd1:    b = cmd.addr[7:0];
        3'd2:    b = cmd.addr[15:8];
        3'd3:    b = {4'h0, cmd.we};
        3'd4:    b = cmd.wdata[7:0];
        3'd5:    b = cmd.wdata[15:8];
        3'd6:    b = cmd.wdata[23:16];
        default: b = cmd.wdata[31:24];
      endcase
    end
    return b;
  endfunction

endpackage

// File: rtl/rsp_word_assembler.sv
// Collects read-response bytes (LSB first) into 32-bit words.
// Ports: clk, rst (sync, active-high), clr (hold empty), byte_valid/byte_data
// (incoming byte), word_valid_c/word_c (combinational: this byte completes a word).
module rsp_word_assembler
  import mem_access_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              byte_valid,
  input  logic [7:0]        byte_data,
  output logic              word_valid_c,
  output logic [DATA_W-1:0] word_c
);

  logic [DATA_W-1:0] shift_q;
  logic [1:0]        cnt_q;

  // New byte enters at the top so the first byte ends up in bits [7:0].
  assign word_c       = {byte_data, shift_q[DATA_W-1:8]};
  assign word_valid_c = byte_valid && (cnt_q == 2'd3);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      shift_q <= '0;
      cnt_q   <= '0;
    end else if (byte_valid) begin
      shift_q <= word_c;
      cnt_q   <= cnt_q + 2'd1;
    end
  end

endmodule

// File: rtl/mem_access_host.sv
// UART memory-access initiator: serializes write/read commands into byte frames
// and reassembles read-response bytes into addressed 32-bit words.
// Ports: cmd_* (valid/ready command in), tx_* (byte transmitter), rx_* (byte
// receiver), rsp_* (read words out), done/err (completion pulses). All outputs
// are registered; clk with synchronous active-high rst.
module mem_access_host
  import mem_access_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_rw,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [ADDR_W-1:0] cmd_end_addr,
  input  logic [3:0]        cmd_we,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic [7:0]        tx_data,
  output logic              tx_start,
  input  logic              tx_done,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_data,
  output logic [ADDR_W-1:0] rsp_addr,
  output logic              rsp_last,
  output logic              done,
  output logic              err
);

  localparam int unsigned TMO_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

  state_e            state_q, state_d;
  cmd_t              cmd_q, cmd_d;
  logic [2:0]        idx_q, idx_d;
  logic [ADDR_W-1:0] cur_addr_q, cur_addr_d;
  logic [TMO_W-1:0]  tmo_q, tmo_d;

  logic              cmd_ready_d, tx_start_d, rsp_valid_d, rsp_last_d, done_d, err_d;
  logic [7:0]        tx_data_d;
  logic [DATA_W-1:0] rsp_data_d;
  logic [ADDR_W-1:0] rsp_addr_d;

  logic [ADDR_W-1:0] start_al, end_al;
  logic              tmo_hit, last_byte, in_recv;
  logic              word_valid_c;
  logic [DATA_W-1:0] word_c;

  assign start_al  = {cmd_addr[ADDR_W-1:2], 2'b00};
  assign end_al    = {cmd_end_addr[ADDR_W-1:2], 2'b00};
  assign tmo_hit   = (tmo_q == TMO_W'(TIMEOUT_CYCLES - 1));
  assign last_byte = (idx_q == (cmd_q.rw ? 3'(RD_FRAME_LEN - 1) : 3'(WR_FRAME_LEN - 1)));
  assign in_recv   = (state_q == ST_RECV);

  // Assembler is held empty outside RECV, so stray bytes and partial words vanish.
  rsp_word_assembler u_asm (
    .clk          (clk),
    .rst          (rst),
    .clr          (!in_recv),
    .byte_valid   (rx_valid && in_recv),
    .byte_data    (rx_data),
    .word_valid_c (word_valid_c),
    .word_c       (word_c)
  );

  // Next-state and next-output logic.
  always_comb begin
    state_d     = state_q;
    cmd_d       = cmd_q;
    idx_d       = idx_q;
    cur_addr_d  = cur_addr_q;
    tx_data_d   = tx_data;
    tx_start_d  = 1'b0;
    rsp_valid_d = 1'b0;
    rsp_data_d  = rsp_data;
    rsp_addr_d  = rsp_addr;
    rsp_last_d  = 1'b0;
    done_d      = 1'b0;
    err_d       = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (cmd_valid && cmd_ready) begin
          if (cmd_rw && (end_al < start_al)) begin
            err_d = 1'b1;
          end else begin
            cmd_d      = '{rw: cmd_rw, addr: start_al, end_addr: end_al,
                           we: cmd_we, wdata: cmd_wdata};
            cur_addr_d = start_al;
            idx_d      = 3'd0;
            state_d    = ST_LOAD;
          end
        end
      end
      ST_LOAD: begin
        tx_data_d  = frame_byte(cmd_q, idx_q);
        tx_start_d = 1'b1;
        state_d    = ST_WAIT_TX;
      end
      ST_WAIT_TX: begin
        if (tx_done) begin
          if (last_byte) begin
            state_d = cmd_q.rw ? ST_RECV : ST_FIN;
          end else begin
            idx_d   = idx_q + 3'd1;
            state_d = ST_LOAD;
          end
        end else if (tmo_hit) begin
          err_d   = 1'b1;
          state_d = ST_IDLE;
        end
      end
      ST_RECV: begin
        if (word_valid_c) begin
          rsp_valid_d = 1'b1;
          rsp_data_d  = word_c;
          rsp_addr_d  = cur_addr_q;
          cur_addr_d  = cur_addr_q + ADDR_W'(4);
          // Last word is the one at end_addr; start <= end is guaranteed here.
          if (cur_addr_q == cmd_q.end_addr) begin
            rsp_last_d = 1'b1;
            done_d     = 1'b1;
            state_d    = ST_IDLE;
          end
        end else if (!rx_valid && tmo_hit) begin
          err_d   = 1'b1;
          state_d = ST_IDLE;
        end
      end
      ST_FIN: begin
        done_d  = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    // Ready stays low through the done/err cycle itself.
    cmd_ready_d = (state_d == ST_IDLE) && !done_d && !err_d;
    tmo_d = ((state_d != state_q) || tx_done || rx_valid) ? '0 : tmo_q + TMO_W'(1);
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      cmd_q      <= '0;
      idx_q      <= '0;
      cur_addr_q <= '0;
      tmo_q      <= '0;
      cmd_ready  <= 1'b0;
      tx_data    <= '0;
      tx_start   <= 1'b0;
      rsp_valid  <= 1'b0;
      rsp_data   <= '0;
      rsp_addr   <= '0;
      rsp_last   <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
    end else begin
      state_q    <= state_d;
      cmd_q      <= cmd_d;
      idx_q      <= idx_d;
      cur_addr_q <= cur_addr_d;
      tmo_q      <= tmo_d;
      cmd_ready  <= cmd_ready_d;
      tx_data    <= tx_data_d;
      tx_start   <= tx_start_d;
      rsp_valid  <= rsp_valid_d;
      rsp_data   <= rsp_data_d;
      rsp_addr   <= rsp_addr_d;
      rsp_last   <= rsp_last_d;
      done       <= done_d;
      err        <= err_d;
    end
  end

endmodule
